ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 INHIBIT_CYCLES, default 2500: clk cycles that ps2 clock is held low before the start bit (100 us at 25 MHz).
REQ-002 TIMEOUT_CYCLES, default 375000: maximum clk cycles from releasing ps2 clock to the ACK sample (15 ms at 25 MHz).
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 tx_data  input  8  command byte to send to the device.
REQ-006 tx_valid  input  1  request; tx_data is accepted when tx_valid && tx_ready.
REQ-007 tx_ready  output  1  high only in IDLE.
REQ-008 ps2_clk_in  input  1  raw ps2 clock line level (asynchronous).
REQ-009 ps2_data_in  input  1  raw ps2 data line level (asynchronous).
REQ-010 ps2_clk_oe  output  1  1 = drive ps2 clock low; 0 = release (pulled up).
REQ-011 ps2_data_oe  output  1  1 = drive ps2 data low; 0 = release.
REQ-012 busy  output  1  high in every state except IDLE; the PS/2 receiver ignores the line while busy.
REQ-013 done  output  1  one-cycle pulse: byte sent and ACK received.
REQ-014 error  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-015 ps2_clk_in and ps2_data_in shall each pass through a 2-flop synchronizer; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-016 States: IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: oe outputs 0; on tx_valid, latch tx_data, compute odd parity (parity bit = ~^tx_data), zero the cycle counter, go to INHIBIT.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0; zero the timeout counter and bit index; go to SEND next cycle.
REQ-020 SEND: on each falling edge drive the next frame bit: D0..D7 LSB first, then parity, then stop (release, 1); bit value b gives ps2_data_oe = ~b.
REQ-021 After the falling edge that places the stop bit (10th falling edge in SEND), go to ACK.
REQ-022 ACK: on the next falling edge sample synced data; 0 = ACK, go to WAIT_IDLE; 1 = pulse error, go to IDLE.
REQ-023 WAIT_IDLE: when synced clock and data are both 1, pulse done and go to IDLE.
REQ-024 The timeout counter runs from START through WAIT_IDLE; reaching TIMEOUT_CYCLES pulses error, releases both lines and goes to IDLE, in every one of those states.
REQ-025 tx_valid outside IDLE shall be ignored; tx_data is not re-sampled until the next accept.
REQ-026 done and error shall never be high in the same cycle; each pulses at most once per accepted byte.
REQ-027 The bit index shall be 4 bits; counters shall be wide enough for TIMEOUT_CYCLES (≥19 bits at the default).

Reset
REQ-028 On reset: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, error=0, counters and bit index 0.
REQ-029 Reset asserted mid-frame shall abort within the same cycle, release both lines, and produce no done/error pulse.

Verification
REQ-030 Send 0x01, device model clocks 11 edges, ACK low → ps2_clk_oe high for 2500 cycles; data bits 1,0,0,0,0,0,0,0, parity 0, stop 1; one done pulse; tx_ready returns to 1.
REQ-031 Send 0xED, device answers with ACK=1 on edge 11 → bits 1,0,1,1,0,1,1,1, parity 1; one error pulse; no done.
REQ-032 Device never clocks after the clock line is released → error exactly TIMEOUT_CYCLES after START; both oe at 0.
REQ-033 tx_valid held high with 0xFF then 0x55 during busy → 0xFF frame only (parity 1); 0x55 is accepted after return to IDLE.
REQ-034 reset pulsed after the 4th falling edge → oe outputs 0 on the next cycle; no done/error pulse; the next request sends a clean frame.
REQ-035 Device holds data low after ACK for 100 cycles → done fires only on the cycle both synced lines read 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with inhibit, ACK check and timeout.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   tx_data, tx_valid      command byte and request, accepted when tx_valid && tx_ready
//   tx_ready, busy         idle / transfer-in-progress status
//   ps2_clk_in/data_in     raw asynchronous PS/2 line levels
//   ps2_clk_oe/data_oe     open-drain enables, 1 pulls the line low
//   done, error            one-cycle completion / failure pulses
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_idx_q;
    logic [9:0]    frame_q;
    logic          clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
    logic          clk_oe_q, data_oe_q, done_q, error_q;
    logic          fall;
    logic          timed;

    assign fall        = clk_prev_q & ~clk_s2_q;
    assign timed       = (state_q inside {START, SEND, ACK, WAIT_IDLE}) && cnt_q == TO_LAST;
    assign tx_ready    = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign error       = error_q;

    // Idle-high reset values keep a reset from looking like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            {clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q} <= '1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    // frame_q holds {stop, parity, D7..D0} so bit_idx_q selects the next line value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (timed) begin
                error_q   <= 1'b1;
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                state_q   <= IDLE;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (tx_valid) begin
                            frame_q  <= {1'b1, ~^tx_data, tx_data};
                            clk_oe_q <= 1'b1;
                            state_q  <= INHIBIT;
                        end
                    end
                    INHIBIT: if (cnt_q == INH_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        state_q   <= START;
                    end
                    START: state_q <= SEND;
                    SEND: if (fall) begin
                        data_oe_q <= ~frame_q[bit_idx_q];
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 4'd9) state_q <= ACK;
                    end
                    ACK: if (fall) begin
                        error_q <= data_s2_q;
                        state_q <= data_s2_q ? IDLE : WAIT_IDLE;
                    end
                    WAIT_IDLE: if (clk_s2_q && data_s2_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench driving ps2_host_tx against a PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 2500;
    localparam int TO  = 20000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;
    int         compared = 0;
    int         mismatched = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
    end

    // Bits as they should appear on the wire after each device falling edge:
    // D0..D7, odd parity (set when the data has an even count of ones), stop = 1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones;
        logic [9:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: measure the inhibit, wait for the start bit, then generate
    // 11 clocks, sampling the host's bit late in each low phase and driving ack
    // before the 11th edge. abort_edge > 0 stops clocking after that edge.
    task automatic device_frame(input logic ack, input int hold, input int abort_edge,
                                output logic [9:0] cap, output int inh, output bit ok);
        int t;
        cap = '0;
        inh = 0;
        ok  = 1'b1;
        t   = 0;
        while (!ps2_clk_oe && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ps2_clk_oe) begin
            ok = 1'b0;
            return;
        end
        while (ps2_clk_oe && inh < 4 * INH) begin
            inh++;
            @(negedge clk);
        end
        t = 0;
        while (data_line && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (data_line) begin
            ok = 1'b0;
            return;
        end
        repeat (30) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11) dev_data = ack;
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (e <= 10) cap[e-1] = data_line;
            dev_clk = 1'b1;
            if (e == abort_edge) return;
        end
        repeat (hold) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (ps2_clk_oe !== 1'b0) begin mismatched++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
        compared++;
        if (ps2_data_oe !== 1'b0) begin mismatched++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
        compared++;
        if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++;
        if (done !== 1'b0 || error !== 1'b0) begin mismatched++; $display("FAIL reset_pulses: got done=%b error=%b expected 0 0", done, error); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ok(input logic [7:0] b);
        logic [9:0] cap;
        int inh, t, d0, e0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b);
        compared++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin mismatched++; $display("FAIL accept_busy %02h: got busy=%b ready=%b expected 1 0", b, busy, tx_ready); end
        device_frame(1'b0, 0, 0, cap, inh, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL handshake %02h: got no start bit expected start bit", b); end
        compared++;
        if (inh !== INH) begin mismatched++; $display("FAIL inhibit %02h: got %0d expected %0d", b, inh, INH); end
        compared++;
        if (cap !== model_frame(b)) begin mismatched++; $display("FAIL frame %02h: got %03h expected %03h", b, cap, model_frame(b)); end
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("FAIL done_seen %02h: got %b expected 1", b, done); end
        repeat (5) @(negedge clk);
        compared++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin mismatched++; $display("FAIL pulses %02h: got done=%0d error=%0d expected 1 0", b, done_cnt - d0, err_cnt - e0); end
        compared++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after %02h: got ready=%b busy=%b oe=%b%b expected 1 0 00", b, tx_ready, busy, ps2_clk_oe, ps2_data_oe);
        end
    endtask

    task automatic test_nack;
        logic [9:0] cap;
        int inh, d0, e0;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hED);
        device_frame(1'b1, 0, 0, cap, inh, ok);
        compared++;
        if (!ok || cap !== model_frame(8'hED)) begin mismatched++; $display("FAIL nack_frame: got %03h expected %03h", cap, model_frame(8'hED)); end
        repeat (40) @(negedge clk);
        compared++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin mismatched++; $display("FAIL nack_pulses: got error=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0); end
        compared++;
        if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL nack_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_timeout;
        int t, k, e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        send_byte(8'($urandom));
        t = 0;
        while (ps2_clk_oe && t < 4 * INH) begin
            @(negedge clk);
            t++;
        end
        k = 0;
        while (!error && k < TO + 100) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (k !== TO) begin mismatched++; $display("FAIL timeout_cycles: got %0d expected %0d", k, TO); end
        compared++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_release: got oe=%b%b busy=%b expected 00 0", ps2_clk_oe, ps2_data_oe, busy);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin mismatched++; $display("FAIL timeout_pulses: got error=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] cap;
        int inh, t, d0;
        bit ok;
        d0 = done_cnt;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        device_frame(1'b0, 0, 0, cap, inh, ok);
        compared++;
        if (!ok || cap !== model_frame(8'hFF)) begin mismatched++; $display("FAIL b2b_first: got %03h expected %03h", cap, model_frame(8'hFF)); end
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (done !== 1'b1 || tx_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_idle: got done=%b ready=%b expected 1 1", done, tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
        device_frame(1'b0, 0, 0, cap, inh, ok);
        compared++;
        if (!ok || cap !== model_frame(8'h55)) begin mismatched++; $display("FAIL b2b_second: got %03h expected %03h", cap, model_frame(8'h55)); end
        repeat (20) @(negedge clk);
        compared++;
        if (done_cnt - d0 !== 2) begin mismatched++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] cap, exp;
        logic [7:0] b;
        int inh, d0, e0;
        bit ok;
        b   = 8'($urandom);
        exp = model_frame(b);
        d0  = done_cnt;
        e0  = err_cnt;
        send_byte(b);
        device_frame(1'b0, 0, 4, cap, inh, ok);
        compared++;
        if (!ok || cap[3:0] !== exp[3:0]) begin mismatched++; $display("FAIL abort_bits: got %01h expected %01h", cap[3:0], exp[3:0]); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_release: got oe=%b%b busy=%b ready=%b expected 00 0 1", ps2_clk_oe, ps2_data_oe, busy, tx_ready);
        end
        repeat (100) @(negedge clk);
        compared++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin mismatched++; $display("FAIL abort_pulses: got done=%0d error=%0d expected 0 0", done_cnt - d0, err_cnt - e0); end
        test_send_ok(8'($urandom));
    endtask

    // Released data must pass two sync flops and then the registered done,
    // so done shows three cycles after the line rises and never before.
    task automatic test_ack_hold;
        logic [9:0] cap;
        logic [7:0] b;
        int inh, t, d0;
        bit ok;
        b  = 8'($urandom);
        d0 = done_cnt;
        send_byte(b);
        device_frame(1'b0, 100, 0, cap, inh, ok);
        compared++;
        if (!ok || cap !== model_frame(b)) begin mismatched++; $display("FAIL hold_frame: got %03h expected %03h", cap, model_frame(b)); end
        compared++;
        if (done_cnt - d0 !== 0 || busy !== 1'b1) begin mismatched++; $display("FAIL hold_early: got done=%0d busy=%b expected 0 1", done_cnt - d0, busy); end
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        compared++;
        if (t !== 3) begin mismatched++; $display("FAIL hold_latency: got %0d expected 3", t); end
        repeat (5) @(negedge clk);
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL hold_done: got %0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_send_ok(8'h01);
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        test_ack_hold();
        for (int i = 0; i < 3; i++) test_send_ok(8'($urandom));
        compared++;
        if (both_cnt !== 0) begin mismatched++; $display("FAIL done_error_overlap: got %0d expected 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
